// File: rtl/mem_pkg.sv
// Shared widths, arbiter state encoding and the byte-lane merge used by the
// read-modify-write path of mem_arbiter.
package mem_pkg;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_t;

  function automatic logic [MEM_DATA_W-1:0] be_merge(
    input logic [MEM_DATA_W-1:0] data,
    input logic [MEM_DATA_W-1:0] old,
    input logic [MEM_BE_W-1:0]   be
  );
    logic [MEM_DATA_W-1:0] merged;
    merged = old;
    for (int k = 0; k < MEM_BE_W; k++) begin
      if (be[k]) merged[8*k +: 8] = data[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin for the RAM read port: fetch versus data (load or
// partial-store read). Priority flips only on cycles where both ask.
module mem_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic fetch_req,
  input  logic data_req,
  output logic fetch_gnt,
  output logic data_gnt
);

  // rr_last = 1: fetch won the last contended cycle, so data goes next
  logic rr_last;

  assign fetch_gnt = fetch_req && (!data_req || !rr_last);
  assign data_gnt  = data_req && (!fetch_req || rr_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= 1'b0;
    end else if (fetch_req && data_req) begin
      rr_last <= fetch_gnt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one read port and one write port of the word RAM between instruction
// fetch and the data port, sequencing partial stores as read-then-merge.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | accept fetch / load / stores; partial store issues its read
//   ST_MERGE | write merged word of the pending partial store; fetch only
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_w_addr,
  output logic [DATA_W-1:0]   ram_w_data,
  output logic [ADDR_W-1:0]   ram_r_addr,
  input  logic [DATA_W-1:0]   ram_r_data
);

  localparam int BE_W = DATA_W / 8;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rmw_addr_q;
  logic [BE_W-1:0]     rmw_be_q;
  logic [DATA_W-1:0]   rmw_wdata_q;
  logic [ADDR_W-1:0]   r_addr_q, w_addr_q;
  logic                i_own_q, d_own_q;

  logic d_full, d_none, d_rd;
  logic arb_i_req, arb_d_req, arb_i_gnt, arb_d_gnt;

  assign d_full = d_we && (d_be == '1);
  assign d_none = d_we && (d_be == '0);
  // loads and partial stores are the data side's read-port contenders
  assign d_rd   = d_req && !d_full && !d_none;

  assign arb_i_req = i_req && (state_q == ST_IDLE) && !rst;
  assign arb_d_req = d_rd && (state_q == ST_IDLE) && !rst;

  mem_rr_arb u_rr_arb (
    .clk       (clk),
    .rst       (rst),
    .fetch_req (arb_i_req),
    .data_req  (arb_d_req),
    .fetch_gnt (arb_i_gnt),
    .data_gnt  (arb_d_gnt)
  );

  always_comb begin
    state_d    = state_q;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    ram_we     = 1'b0;
    ram_w_addr = w_addr_q;
    ram_w_data = '0;
    ram_r_addr = r_addr_q;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (d_req && (d_full || d_none)) begin
            d_gnt = 1'b1;
            if (d_full) begin
              ram_we     = 1'b1;
              ram_w_addr = d_addr;
              ram_w_data = d_wdata;
            end
          end
          if (arb_d_gnt) begin
            d_gnt      = 1'b1;
            ram_r_addr = d_addr;
            if (d_we) state_d = ST_MERGE;
          end
          if (arb_i_gnt) begin
            i_gnt      = 1'b1;
            ram_r_addr = i_addr;
          end
        end
        ST_MERGE: begin
          ram_we     = 1'b1;
          ram_w_addr = rmw_addr_q;
          ram_w_data = be_merge(rmw_wdata_q, ram_r_data, rmw_be_q);
          state_d    = ST_IDLE;
          if (i_req) begin
            i_gnt      = 1'b1;
            ram_r_addr = i_addr;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rmw_addr_q  <= '0;
      rmw_be_q    <= '0;
      rmw_wdata_q <= '0;
      r_addr_q    <= '0;
      w_addr_q    <= '0;
      i_own_q     <= 1'b0;
      d_own_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_addr_q <= ram_r_addr;
      w_addr_q <= ram_w_addr;
      i_own_q  <= i_gnt;
      d_own_q  <= d_gnt && !d_we;
      if (arb_d_gnt && d_we) begin
        rmw_addr_q  <= d_addr;
        rmw_be_q    <= d_be;
        rmw_wdata_q <= d_wdata;
      end
    end
  end

  assign i_rvalid = i_own_q;
  assign d_rvalid = d_own_q;
  assign i_rdata  = i_own_q ? ram_r_data : '0;
  assign d_rdata  = d_own_q ? ram_r_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, word-level reference memory with a
// per-cycle expectation checker, directed sequences, a vector table and random traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req, i_gnt, i_rvalid;
  logic [13:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [13:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata, d_rdata;
  logic        ram_we;
  logic [13:0] ram_w_addr, ram_r_addr;
  logic [31:0] ram_w_data, ram_r_data;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_we(ram_we), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram_mem [logic [13:0]];
  logic [31:0] ref_mem [logic [13:0]];

  function automatic logic [31:0] init_word(input logic [13:0] a);
    if (a == 14'h0200) return 32'h11223344;
    if (a == 14'h0300) return 32'h0;
    return {18'h2A5A5, a};
  endfunction

  function automatic logic [31:0] ram_peek(input logic [13:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_peek(input logic [13:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // RAM: registered read, read sees the pre-write contents on collision
  always @(posedge clk) begin
    ram_r_data <= ram_peek(ram_r_addr);
    if (ram_we) ram_mem[ram_w_addr] = ram_w_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model state: word memory, pending merge, who is favoured, pending returns
  bit          m_merge, m_ffav, m_irv, m_drv;
  logic [13:0] m_maddr;
  logic [31:0] m_mval, m_idat, m_ddat;
  bit          seen_ig, seen_dg;

  task automatic model_reset();
    m_merge = 0; m_ffav = 1; m_irv = 0; m_drv = 0;
    seen_ig = 0; seen_dg = 0;
  endtask

  task automatic model_cycle();
    bit full, none, rd, win_i, e_ig, e_dg, e_we, nxt_merge;
    logic [13:0] e_wa;
    logic [31:0] e_wd, old;
    full = d_req && d_we && (d_be == 4'hF);
    none = d_req && d_we && (d_be == 4'h0);
    rd   = d_req && !full && !none;
    e_we = 0; e_wa = 0; e_wd = 0;
    if (m_merge) begin
      e_ig = i_req; e_dg = 0;
      e_we = 1; e_wa = m_maddr; e_wd = m_mval;
    end else begin
      if (rd && i_req) begin
        win_i  = m_ffav;
        m_ffav = !m_ffav;
      end else begin
        win_i = i_req;
      end
      e_ig = i_req && win_i;
      e_dg = full || none || (rd && !win_i);
      if (full) begin e_we = 1; e_wa = d_addr; e_wd = d_wdata; end
    end
    chk("i_gnt", 64'(i_gnt), 64'(e_ig));
    chk("d_gnt", 64'(d_gnt), 64'(e_dg));
    chk("ram_we", 64'(ram_we), 64'(e_we));
    if (e_we) begin
      chk("ram_w_addr", 64'(ram_w_addr), 64'(e_wa));
      chk("ram_w_data", 64'(ram_w_data), 64'(e_wd));
    end
    if (e_ig) chk("ram_r_addr_i", 64'(ram_r_addr), 64'(i_addr));
    else if (e_dg && rd) chk("ram_r_addr_d", 64'(ram_r_addr), 64'(d_addr));
    chk("i_rvalid", 64'(i_rvalid), 64'(m_irv));
    if (m_irv) chk("i_rdata", 64'(i_rdata), 64'(m_idat));
    chk("d_rvalid", 64'(d_rvalid), 64'(m_drv));
    if (m_drv) chk("d_rdata", 64'(d_rdata), 64'(m_ddat));
    // next-cycle expectations use memory contents before this cycle's write
    m_irv = e_ig;
    if (e_ig) m_idat = ref_peek(i_addr);
    m_drv = e_dg && rd && !d_we;
    if (m_drv) m_ddat = ref_peek(d_addr);
    nxt_merge = e_dg && rd && d_we;
    if (nxt_merge) begin
      m_maddr = d_addr;
      old = ref_peek(d_addr);
      for (int k = 0; k < 4; k++) m_mval[8*k +: 8] = d_be[k] ? d_wdata[8*k +: 8] : old[8*k +: 8];
    end
    if (e_we) ref_mem[e_wa] = e_wd;
    m_merge = nxt_merge;
    seen_ig = i_gnt;
    seen_dg = d_gnt;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctl", 64'({i_gnt, i_rvalid, d_gnt, d_rvalid, ram_we}), 64'(0));
      chk("rst_rdata", 64'({i_rdata, d_rdata}), 64'(0));
      chk("rst_ram", 64'({ram_w_addr, ram_r_addr, ram_w_data}), 64'(0));
      model_reset();
    end else begin
      model_cycle();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_be = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic        ir;
    logic [13:0] ia;
    logic        dr;
    logic        dwe;
    logic [3:0]  dbe;
    logic [13:0] da;
    logic [31:0] dwd;
    logic [2:0]  exp_gnt_we;  // {i_gnt, d_gnt, ram_we}
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic ir, input logic [13:0] ia, input logic dr, input logic dwe,
                         input logic [3:0] dbe, input logic [13:0] da, input logic [31:0] dwd,
                         input logic [2:0] e);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.dbe = dbe; v.da = da; v.dwd = dwd;
    v.exp_gnt_we = e;
    tbl.push_back(v);
  endtask

  initial begin
    idle_inputs();
    // table runs from a fresh reset, so the first contention goes to fetch
    add_vec(1, 14'h40, 0, 0, 4'h0, 14'h00, 32'h0,        3'b100);
    add_vec(0, 14'h00, 1, 0, 4'h0, 14'h41, 32'h0,        3'b010);
    add_vec(1, 14'h42, 1, 1, 4'hF, 14'h43, 32'hCAFEF00D, 3'b111);
    add_vec(1, 14'h44, 1, 1, 4'h0, 14'h45, 32'h12345678, 3'b110);
    add_vec(1, 14'h46, 1, 0, 4'h0, 14'h43, 32'h0,        3'b100);
    add_vec(1, 14'h46, 1, 0, 4'h0, 14'h43, 32'h0,        3'b010);
    add_vec(0, 14'h00, 0, 0, 4'h0, 14'h00, 32'h0,        3'b000);
    add_vec(1, 14'h47, 1, 1, 4'h4, 14'h48, 32'h00990000, 3'b100);
    add_vec(1, 14'h47, 1, 1, 4'h4, 14'h48, 32'h00990000, 3'b010);
    add_vec(1, 14'h49, 1, 0, 4'h0, 14'h48, 32'h0,        3'b101);
    add_vec(0, 14'h00, 1, 0, 4'h0, 14'h48, 32'h0,        3'b010);
    add_vec(0, 14'h00, 0, 0, 4'h0, 14'h00, 32'h0,        3'b000);

    // reset with every request high
    i_req = 1; i_addr = 14'h1; d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 14'h2;
    @(negedge clk);
    chk("reset_outs", 64'({i_gnt, d_gnt, ram_we, i_rvalid, d_rvalid}), 64'(0));
    tick(); idle_inputs(); tick(); rst = 0;

    // first fetch after reset
    i_req = 1; i_addr = 14'h0010;
    @(negedge clk); chk("f0_gnt", 64'(i_gnt), 64'(1));
    tick(); idle_inputs();
    @(negedge clk);
    chk("f0_rvalid", 64'(i_rvalid), 64'(1));
    chk("f0_rdata", 64'(i_rdata), 64'(init_word(14'h0010)));
    tick();

    // full store alongside a fetch, then load it back
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 14'h0100; d_wdata = 32'hDEADBEEF;
    i_req = 1; i_addr = 14'h0004;
    @(negedge clk);
    chk("fs_gnts", 64'({i_gnt, d_gnt, ram_we}), 64'(3'b111));
    chk("fs_wdata", 64'(ram_w_data), 64'(32'hDEADBEEF));
    tick(); idle_inputs(); d_req = 1; d_addr = 14'h0100;
    @(negedge clk);
    chk("fs_ld_gnt", 64'(d_gnt), 64'(1));
    chk("fs_fetch_data", 64'(i_rdata), 64'(init_word(14'h0004)));
    tick(); idle_inputs();
    @(negedge clk);
    chk("fs_ld_data", 64'({d_rvalid, d_rdata}), 64'({1'b1, 32'hDEADBEEF}));
    tick();

    // partial store: read, then merge; second data request waits, fetch goes in MERGE
    d_req = 1; d_we = 1; d_be = 4'b0010; d_addr = 14'h0200; d_wdata = 32'h0000AB00;
    @(negedge clk);
    chk("ps_gnt", 64'({d_gnt, ram_we}), 64'(2'b10));
    chk("ps_raddr", 64'(ram_r_addr), 64'(14'h0200));
    tick(); d_we = 0; d_be = 0; d_wdata = 0; i_req = 1; i_addr = 14'h0008;
    @(negedge clk);
    chk("ps_merge_gnts", 64'({i_gnt, d_gnt, ram_we}), 64'(3'b101));
    chk("ps_merge_w", 64'({ram_w_addr, ram_w_data}), 64'({14'h0200, 32'h1122AB44}));
    tick(); i_req = 0;
    @(negedge clk);
    chk("ps_next_gnt", 64'(d_gnt), 64'(1));
    tick(); idle_inputs();
    @(negedge clk);
    chk("ps_readback", 64'({d_rvalid, d_rdata}), 64'({1'b1, 32'h1122AB44}));
    tick();

    // same-address collision returns old data; the next fetch sees the new word
    i_req = 1; i_addr = 14'h0300;
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 14'h0300; d_wdata = 32'h55AA55AA;
    @(negedge clk); chk("col_gnts", 64'({i_gnt, d_gnt}), 64'(2'b11));
    tick(); d_req = 0; d_we = 0; d_be = 0;
    @(negedge clk);
    chk("col_old", 64'({i_rvalid, i_rdata}), 64'({1'b1, 32'h0}));
    tick(); i_req = 0;
    @(negedge clk);
    chk("col_new", 64'({i_rvalid, i_rdata}), 64'({1'b1, 32'h55AA55AA}));
    tick();

    // contention after reset: F,D,F,D,F,D with returns routed to the right port
    do_reset();
    i_req = 1; i_addr = 14'h0020; d_req = 1; d_we = 0; d_addr = 14'h0021;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_gnt", 64'({i_gnt, d_gnt}), 64'((k % 2 == 0) ? 2'b10 : 2'b01));
      if (k > 0) chk("rr_route", 64'({i_rvalid, d_rvalid}), 64'((k % 2 == 1) ? 2'b10 : 2'b01));
      tick();
    end
    idle_inputs();
    tick();

    // reset in the MERGE cycle abandons the write
    d_req = 1; d_we = 1; d_be = 4'b1001; d_addr = 14'h0205; d_wdata = 32'hFFFFFFFF;
    @(negedge clk); chk("rm_gnt", 64'(d_gnt), 64'(1));
    tick(); idle_inputs(); i_req = 1; i_addr = 14'h0031; rst = 1;
    @(negedge clk); chk("rm_no_we", 64'({ram_we, i_gnt}), 64'(0));
    tick(); idle_inputs(); tick(); rst = 0;
    @(negedge clk); chk("rm_rv", 64'({i_rvalid, d_rvalid, ram_we}), 64'(0));
    tick(); d_req = 1; d_we = 0; d_addr = 14'h0205;
    @(negedge clk); chk("rm_ld_gnt", 64'(d_gnt), 64'(1));
    tick(); idle_inputs();
    @(negedge clk); chk("rm_mem", 64'({d_rvalid, d_rdata}), 64'({1'b1, init_word(14'h0205)}));
    tick();

    // vector table
    do_reset();
    foreach (tbl[n]) begin
      i_req = tbl[n].ir; i_addr = tbl[n].ia;
      d_req = tbl[n].dr; d_we = tbl[n].dwe; d_be = tbl[n].dbe; d_addr = tbl[n].da; d_wdata = tbl[n].dwd;
      @(negedge clk);
      chk($sformatf("tbl%0d", n), 64'({i_gnt, d_gnt, ram_we}), 64'(tbl[n].exp_gnt_we));
      tick();
    end
    idle_inputs();
    tick();

    // random traffic, requests held with stable fields until granted
    for (int c = 0; c < 3000; c++) begin
      if (!i_req || seen_ig) begin
        i_req  = ($urandom_range(0, 99) < 60);
        i_addr = 14'($urandom_range(0, 15));
      end
      if (!d_req || seen_dg) begin
        d_req   = ($urandom_range(0, 99) < 60);
        d_we    = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       d_be = 4'h0;
          1:       d_be = 4'hF;
          default: d_be = 4'($urandom_range(0, 15));
        endcase
        d_addr  = 14'($urandom_range(0, 15));
        d_wdata = $urandom();
      end
      @(negedge clk);
      tick();
    end
    idle_inputs();
    tick(); tick(); tick();

    for (int a = 0; a < 16; a++) begin
      chk($sformatf("mem%0d", a), 64'(ram_peek(14'(a))), 64'(ref_peek(14'(a))));
    end
    chk("mem_0205", 64'(ram_peek(14'h0205)), 64'(ref_peek(14'h0205)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
